// File: rtl/first_m.sv
// rtl/first_m.sv - five-input registered threshold voter with glitch filter
module first_m #(
    parameter int THRESHOLD    = 3,
    parameter int FILTER_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    output logic       F,
    output logic [2:0] COUNT
);

    // Parameters narrowed once so every comparison below is width-matched.
    localparam logic [2:0] THR_VAL    = 3'(THRESHOLD);
    localparam logic [3:0] LAST_COUNT = 4'(FILTER_DEPTH - 1);

    // Reject out-of-range parameters while the design is being elaborated.
    generate
        if (THRESHOLD < 1 || THRESHOLD > 5) begin : g_bad_threshold
            $error("first_m: THRESHOLD must be in 1..5");
        end
        if (FILTER_DEPTH < 1 || FILTER_DEPTH > 15) begin : g_bad_filter_depth
            $error("first_m: FILTER_DEPTH must be in 1..15");
        end
    endgenerate

    logic [2:0] pop_count;
    logic       vote;
    logic [3:0] stab_cnt;
    logic [3:0] stab_next;
    logic       f_next;

    // Popcount of the raw inputs; they are sampled without synchronizers.
    always_comb begin
        pop_count = {2'b00, A} + {2'b00, B} + {2'b00, C} + {2'b00, D} + {2'b00, E};
    end

    // The vote is taken from the registered count, not the raw inputs.
    always_comb begin
        vote = (COUNT >= THR_VAL);
    end

    // Filter: a disagreeing vote must persist FILTER_DEPTH cycles before F follows;
    // any return to agreement clears the run so short pulses never propagate.
    always_comb begin
        f_next    = F;
        stab_next = 4'd0;
        if (vote != F) begin
            if (stab_cnt == LAST_COUNT) begin
                f_next = vote;
            end else begin
                stab_next = stab_cnt + 4'd1;
            end
        end
    end

    // State register; reset wins over any in-flight filter count.
    always_ff @(posedge clk) begin
        if (rst) begin
            COUNT    <= 3'd0;
            F        <= 1'b0;
            stab_cnt <= 4'd0;
        end else begin
            COUNT    <= pop_count;
            F        <= f_next;
            stab_cnt <= stab_next;
        end
    end

endmodule

// File: tb/tb_first_m.sv
// tb/tb_first_m.sv - scoreboard bench for first_m with default parameters
module tb_first_m;

    localparam int THR   = 3;
    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       a, b, c, d, e;
    logic       f;
    logic [2:0] count;

    int total;
    int bad;

    // Reference state, updated once per rising edge.
    int m_count;
    int m_f;
    int m_run;

    typedef struct {
        logic [2:0] count;
        logic       f;
        string      tag;
    } exp_t;

    exp_t sb[$];

    first_m #(
        .THRESHOLD   (THR),
        .FILTER_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .C    (c),
        .D    (d),
        .E    (e),
        .F    (f),
        .COUNT(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference by one edge: the filter sees the count registered before the edge.
    task automatic model_edge(input logic [4:0] v, input bit r);
        int vote;
        if (r) begin
            m_count = 0;
            m_f     = 0;
            m_run   = 0;
        end else begin
            vote = (m_count >= THR) ? 1 : 0;
            if (vote == m_f) begin
                m_run = 0;
            end else if (m_run + 1 >= DEPTH) begin
                m_f   = vote;
                m_run = 0;
            end else begin
                m_run = m_run + 1;
            end
            m_count = $countones(v);
        end
    endtask

    // Drive one cycle at the falling edge, record the expectation, check after the rising edge.
    task automatic step(input logic [4:0] v, input bit r, input string tag);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        {a, b, c, d, e} = v;
        rst = r;
        model_edge(v, r);
        ex.count = 3'(m_count);
        ex.f     = m_f[0];
        ex.tag   = tag;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty: observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            total++;
            assert (count === got.count) else begin
                bad++;
                $error("FAIL %s COUNT: observed=%0d expected=%0d", got.tag, count, got.count);
            end
            total++;
            assert (f === got.f) else begin
                bad++;
                $error("FAIL %s F: observed=%0b expected=%0b", got.tag, f, got.f);
            end
        end
    endtask

    task automatic check_f(input logic exp_f, input string tag);
        total++;
        assert (f === exp_f) else begin
            bad++;
            $error("FAIL %s F: observed=%0b expected=%0b", tag, f, exp_f);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_count = 0;
        m_f     = 0;
        m_run   = 0;
        rst     = 1'b1;
        {a, b, c, d, e} = 5'b11111;

        // Reset held two cycles with all inputs high, then release.
        step(5'b11111, 1'b1, "rst1");
        step(5'b11111, 1'b1, "rst2");
        total++;
        assert (count === 3'd0) else begin
            bad++;
            $error("FAIL reset_count: observed=%0d expected=0", count);
        end
        check_f(1'b0, "reset_f");
        step(5'b11111, 1'b0, "release_cnt5");
        total++;
        assert (count === 3'd5) else begin
            bad++;
            $error("FAIL release_count: observed=%0d expected=5", count);
        end

        // All-low for ten cycles from reset.
        step(5'b00000, 1'b1, "rst_again");
        for (int i = 0; i < 10; i++) step(5'b00000, 1'b0, "zeros");
        check_f(1'b0, "zeros_f");

        // A one-cycle rising glitch must not reach F.
        step(5'b00111, 1'b0, "rise_glitch");
        for (int i = 0; i < 3; i++) step(5'b00000, 1'b0, "after_rise_glitch");
        check_f(1'b0, "rise_glitch_f");

        // Exactly-threshold vote: F rises two edges after COUNT shows 3.
        step(5'b00111, 1'b0, "thr_N");
        check_f(1'b0, "thr_N_f");
        step(5'b00111, 1'b0, "thr_N1");
        check_f(1'b0, "thr_N1_f");
        step(5'b00111, 1'b0, "thr_N2");
        check_f(1'b1, "thr_N2_f");

        // Four then five high: F holds with no dropout.
        step(5'b11101, 1'b0, "cnt4");
        step(5'b11111, 1'b0, "cnt5");
        for (int i = 0; i < 3; i++) step(5'b11111, 1'b0, "hold5");
        check_f(1'b1, "hold5_f");

        // One-cycle falling glitch rejected.
        step(5'b00011, 1'b0, "fall_glitch");
        for (int i = 0; i < 4; i++) step(5'b11111, 1'b0, "after_fall_glitch");
        check_f(1'b1, "fall_glitch_f");

        // Reset arriving mid-filter clears F and the filter count.
        step(5'b00001, 1'b0, "mid_N");
        step(5'b00001, 1'b1, "mid_rst");
        check_f(1'b0, "mid_rst_f");
        total++;
        assert (dut.stab_cnt === 4'd0) else begin
            bad++;
            $error("FAIL mid_rst_stab: observed=%0d expected=0", dut.stab_cnt);
        end
        for (int i = 0; i < 5; i++) step(5'b00001, 1'b0, "post_rst_low");
        check_f(1'b0, "post_rst_low_f");

        // Randomised traffic checked cycle-by-cycle against the reference.
        for (int i = 0; i < 200; i++) begin
            step(5'($urandom_range(0, 31)), ($urandom_range(0, 49) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
